// File: rtl/mul_seq.sv
// Sequential shift-add multiplier: one WIDTH x WIDTH product per WIDTH cycles,
// unsigned or two's-complement per transaction, with valid/ready on both sides.
module mul_seq #(
    parameter int WIDTH = 8
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [WIDTH-1:0]     a,
    input  logic [WIDTH-1:0]     b,
    input  logic                 signed_mode,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [2*WIDTH-1:0]   p
);

    localparam int PW    = 2 * WIDTH;
    localparam int CNT_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;

    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] CALC = 2'd1;
    localparam logic [1:0] DONE = 2'd2;

    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WIDTH - 1);

    logic [1:0]       state_reg;
    logic [WIDTH-1:0] ma_reg;
    logic [WIDTH-1:0] mb_reg;
    logic             neg_reg;
    logic [PW-1:0]    acc_reg;
    logic [CNT_W-1:0] cnt_reg;
    logic [PW-1:0]    p_reg;
    logic             out_valid_reg;

    logic [WIDTH-1:0] a_mag;
    logic [WIDTH-1:0] b_mag;
    logic [PW-1:0]    shifted;
    logic [PW-1:0]    addend;
    logic [PW-1:0]    acc_next;
    logic [PW-1:0]    prod_final;

    // Magnitudes stay unsigned WIDTH-bit, so -2^(WIDTH-1) becomes 2^(WIDTH-1) exactly.
    assign a_mag = (signed_mode & a[WIDTH-1]) ? (~a + WIDTH'(1)) : a;
    assign b_mag = (signed_mode & b[WIDTH-1]) ? (~b + WIDTH'(1)) : b;

    assign shifted = {{WIDTH{1'b0}}, ma_reg} << cnt_reg;

    generate
        for (genvar gi = 0; gi < PW; gi++) begin : g_addend
            assign addend[gi] = mb_reg[0] & shifted[gi];
        end
    endgenerate

    assign acc_next   = acc_reg + addend;
    assign prod_final = neg_reg ? (~acc_next + PW'(1)) : acc_next;

    assign in_ready  = (state_reg == IDLE) & ~rst;
    assign out_valid = out_valid_reg;
    assign p         = p_reg;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg     <= IDLE;
            ma_reg        <= '0;
            mb_reg        <= '0;
            neg_reg       <= 1'b0;
            acc_reg       <= '0;
            cnt_reg       <= '0;
            p_reg         <= '0;
            out_valid_reg <= 1'b0;
        end else begin
            case (state_reg)
                IDLE: begin
                    if (in_valid) begin
                        ma_reg    <= a_mag;
                        mb_reg    <= b_mag;
                        neg_reg   <= signed_mode & (a[WIDTH-1] ^ b[WIDTH-1]);
                        acc_reg   <= '0;
                        cnt_reg   <= '0;
                        state_reg <= CALC;
                    end
                end
                CALC: begin
                    acc_reg <= acc_next;
                    mb_reg  <= mb_reg >> 1;
                    cnt_reg <= cnt_reg + CNT_W'(1);
                    // Fixed WIDTH iterations, no early exit on zero operands.
                    if (cnt_reg == CNT_LAST) begin
                        p_reg         <= prod_final;
                        out_valid_reg <= 1'b1;
                        state_reg     <= DONE;
                    end
                end
                DONE: begin
                    if (out_ready) begin
                        out_valid_reg <= 1'b0;
                        state_reg     <= IDLE;
                    end
                end
                default: state_reg <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_mul_seq.sv
// Bench for mul_seq: WIDTH=8 vector table, random, backpressure and reset cases,
// plus an exhaustive WIDTH=2 instance checked against an integer model.
module tb_mul_seq;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst;
    logic        in_valid, signed_mode, out_ready;
    logic [7:0]  a, b;
    logic        in_ready, out_valid;
    logic [15:0] p;

    logic        in_valid2, sm2, out_ready2;
    logic [1:0]  a2, b2;
    logic        in_ready2, out_valid2;
    logic [3:0]  p2;

    mul_seq #(.WIDTH(8)) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
        .a(a), .b(b), .signed_mode(signed_mode),
        .out_valid(out_valid), .out_ready(out_ready), .p(p)
    );

    mul_seq #(.WIDTH(2)) dut2 (
        .clk(clk), .rst(rst), .in_valid(in_valid2), .in_ready(in_ready2),
        .a(a2), .b(b2), .signed_mode(sm2),
        .out_valid(out_valid2), .out_ready(out_ready2), .p(p2)
    );

    int tests = 0;
    int fails = 0;
    logic [15:0] sb_q[$];
    logic [3:0]  sb2_q[$];

    typedef struct {
        logic [7:0]  a;
        logic [7:0]  b;
        logic        sm;
        logic [15:0] exp;
    } vec_t;
    vec_t vecs[12];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    // Called at a negedge with the DUT idle; returns at a negedge with the DUT idle again.
    task automatic run_txn8(input logic [7:0] ta, input logic [7:0] tb_, input logic tsm,
                            input logic [15:0] texp, input string name);
        int lat;
        logic [15:0] e;
        check({name, " in_ready before accept"}, in_ready, 1);
        in_valid = 1; a = ta; b = tb_; signed_mode = tsm; out_ready = 1;
        sb_q.push_back(texp);
        @(negedge clk);
        in_valid = 0; a = 8'($urandom); b = 8'($urandom); signed_mode = 1'($urandom);
        lat = 0;
        for (int k = 1; k <= 30; k++) begin
            if (out_valid) begin
                lat = k;
                break;
            end
            check({name, " in_ready low while busy"}, in_ready, 0);
            @(negedge clk);
        end
        check({name, " latency"}, lat, 9);
        e = sb_q.pop_front();
        if (lat != 0) begin
            check({name, " in_ready low in DONE"}, in_ready, 0);
            check({name, " product"}, p, e);
            $display("[TB] %s a=0x%02h b=0x%02h signed=%0d p=0x%04h exp=0x%04h lat=%0d",
                     name, ta, tb_, tsm, p, e, lat);
            @(negedge clk);
            check({name, " out_valid one cycle"}, out_valid, 0);
            check({name, " in_ready after handshake"}, in_ready, 1);
        end
    endtask

    task automatic run_txn2(input int ia, input int ib, input int sm);
        int sa, sb, lat;
        logic [3:0] exp, e;
        sa = (sm != 0 && ia >= 2) ? ia - 4 : ia;
        sb = (sm != 0 && ib >= 2) ? ib - 4 : ib;
        exp = 4'((sa * sb) & 15);
        in_valid2 = 1; a2 = 2'(ia); b2 = 2'(ib); sm2 = 1'(sm); out_ready2 = 1;
        sb2_q.push_back(exp);
        @(negedge clk);
        in_valid2 = 0;
        lat = 0;
        for (int k = 1; k <= 10; k++) begin
            if (out_valid2) begin
                lat = k;
                break;
            end
            @(negedge clk);
        end
        check("w2 latency", lat, 3);
        e = sb2_q.pop_front();
        if (lat != 0) begin
            check("w2 product", p2, e);
            $display("[TB] w2 a=%0d b=%0d signed=%0d p=0x%0h exp=0x%0h", ia, ib, sm, p2, e);
            @(negedge clk);
        end
    endtask

    initial begin
        logic [15:0] e;
        logic [7:0]  ra, rb;
        logic        rsm;
        int          sa, sb;
        bit          found;

        vecs[0]  = '{8'h03, 8'h05, 1'b0, 16'h000F};
        vecs[1]  = '{8'hFF, 8'hFF, 1'b0, 16'hFE01};
        vecs[2]  = '{8'h00, 8'hFF, 1'b0, 16'h0000};
        vecs[3]  = '{8'hFD, 8'h05, 1'b1, 16'hFFF1};
        vecs[4]  = '{8'h80, 8'h80, 1'b1, 16'h4000};
        vecs[5]  = '{8'h80, 8'h7F, 1'b1, 16'hC080};
        vecs[6]  = '{8'h7F, 8'h7F, 1'b0, 16'h3F01};
        vecs[7]  = '{8'hFF, 8'hFF, 1'b1, 16'h0001};
        vecs[8]  = '{8'h80, 8'h01, 1'b1, 16'hFF80};
        vecs[9]  = '{8'h80, 8'h02, 1'b0, 16'h0100};
        vecs[10] = '{8'h7F, 8'h81, 1'b1, 16'hC0FF};
        vecs[11] = '{8'h00, 8'h80, 1'b1, 16'h0000};

        rst = 1; in_valid = 0; a = 0; b = 0; signed_mode = 0; out_ready = 0;
        in_valid2 = 0; a2 = 0; b2 = 0; sm2 = 0; out_ready2 = 0;
        repeat (3) @(negedge clk);
        check("reset in_ready low", in_ready, 0);
        rst = 0;
        @(negedge clk);
        check("reset in_ready", in_ready, 1);
        check("reset out_valid", out_valid, 0);
        check("reset p", p, 0);
        check("reset w2 in_ready", in_ready2, 1);

        for (int i = 0; i < 12; i++)
            run_txn8(vecs[i].a, vecs[i].b, vecs[i].sm, vecs[i].exp, $sformatf("vec%0d", i));

        for (int i = 0; i < 8; i++) begin
            ra = 8'($urandom); rb = 8'($urandom); rsm = 1'($urandom);
            sa = rsm ? int'($signed(ra)) : int'(ra);
            sb = rsm ? int'($signed(rb)) : int'(rb);
            run_txn8(ra, rb, rsm, 16'(sa * sb), $sformatf("rnd%0d", i));
        end

        // Backpressure: hold the result 20 cycles while offering ignored operands.
        out_ready = 0; in_valid = 1; a = 8'h12; b = 8'h34; signed_mode = 0;
        sb_q.push_back(16'h03A8);
        @(negedge clk);
        in_valid = 0;
        found = 0;
        for (int k = 0; k < 30; k++) begin
            if (out_valid) begin
                found = 1;
                break;
            end
            @(negedge clk);
        end
        check("bp out_valid seen", found, 1);
        e = sb_q.pop_front();
        for (int k = 0; k < 20; k++) begin
            check("bp out_valid held", out_valid, 1);
            check("bp p stable", p, e);
            check("bp in_ready low", in_ready, 0);
            in_valid = 1; a = 8'($urandom); b = 8'($urandom); signed_mode = 1'($urandom);
            @(negedge clk);
        end
        $display("[TB] backpressure a=0x12 b=0x34 p=0x%04h exp=0x%04h", p, e);
        in_valid = 0; out_ready = 1;
        @(negedge clk);
        check("bp released out_valid", out_valid, 0);
        check("bp released in_ready", in_ready, 1);
        check("bp p kept", p, e);
        run_txn8(8'h0B, 8'h0D, 1'b0, 16'h008F, "after_bp");

        // Reset in cycle 4 of CALC.
        in_valid = 1; a = 8'h55; b = 8'h66; signed_mode = 0; out_ready = 1;
        @(negedge clk);
        in_valid = 0;
        repeat (3) @(negedge clk);
        rst = 1;
        @(negedge clk);
        check("mid rst out_valid", out_valid, 0);
        check("mid rst p", p, 0);
        check("mid rst in_ready low", in_ready, 0);
        rst = 0;
        @(negedge clk);
        check("post rst in_ready", in_ready, 1);
        check("post rst out_valid", out_valid, 0);
        check("post rst p", p, 0);
        $display("[TB] reset mid-CALC a=0x55 b=0x66 aborted");
        run_txn8(8'h07, 8'h09, 1'b0, 16'd63, "after_rst");

        // Reset while DONE holds a result.
        out_ready = 0; in_valid = 1; a = 8'h0A; b = 8'h0A; signed_mode = 0;
        @(negedge clk);
        in_valid = 0;
        repeat (10) @(negedge clk);
        check("done out_valid before rst", out_valid, 1);
        rst = 1;
        @(negedge clk);
        rst = 0;
        check("done rst out_valid", out_valid, 0);
        check("done rst p", p, 0);
        @(negedge clk);
        check("done rst in_ready", in_ready, 1);
        $display("[TB] reset in DONE a=0x0A b=0x0A aborted");

        for (int sm = 0; sm < 2; sm++)
            for (int i = 0; i < 4; i++)
                for (int j = 0; j < 4; j++)
                    run_txn2(i, j, sm);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
